// File: rtl/text_line_pkg.sv
// ============================================================================
// text_line_pkg : shared constants and types for the text line manager
// Revision      : 1.0  initial release
// ============================================================================
`default_nettype none

package text_line_pkg;

  localparam logic [7:0] CH_BS      = 8'h08;
  localparam logic [7:0] CH_CR      = 8'h0D;
  localparam logic [7:0] CH_ESC     = 8'h1B;
  localparam logic [7:0] CH_FF      = 8'h0C;
  localparam logic [7:0] CH_FONT_UP = 8'h11;
  localparam logic [7:0] CH_FONT_DN = 8'h12;
  localparam logic [7:0] CH_COLOR   = 8'h13;
  localparam logic [7:0] CH_SPACE   = 8'h20;
  localparam logic [7:0] CH_TILDE   = 8'h7E;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  typedef logic [1:0] attr_t;

  // One-hot command classes produced by the decoder
  localparam int CMD_W       = 8;
  localparam int CMD_PRINT   = 0;
  localparam int CMD_BS      = 1;
  localparam int CMD_CR      = 2;
  localparam int CMD_ESC     = 3;
  localparam int CMD_FONT_UP = 4;
  localparam int CMD_FONT_DN = 5;
  localparam int CMD_FF      = 6;
  localparam int CMD_COLOR   = 7;

  typedef logic [CMD_W-1:0] cmd_t;

endpackage

`default_nettype wire

// File: rtl/text_cmd_decoder.sv
// ============================================================================
// text_cmd_decoder : classifies a received byte into a one-hot command class
// Build option     : TEXT_LINE_COLOR_EN enables the colour-cycle command
// Revision         : 1.0  initial release
// ============================================================================
`default_nettype none

module text_cmd_decoder
  import text_line_pkg::*;
(
  input  logic [7:0] data,
  output cmd_t       cmd
);

  always_comb begin
    cmd = '0;
    if (data >= CH_SPACE && data <= CH_TILDE) begin
      cmd[CMD_PRINT] = 1'b1;
    end else begin
      case (data)
        CH_BS:      cmd[CMD_BS]      = 1'b1;
        CH_CR:      cmd[CMD_CR]      = 1'b1;
        CH_ESC:     cmd[CMD_ESC]     = 1'b1;
        CH_FONT_UP: cmd[CMD_FONT_UP] = 1'b1;
        CH_FONT_DN: cmd[CMD_FONT_DN] = 1'b1;
        CH_FF:      cmd[CMD_FF]      = 1'b1;
`ifdef TEXT_LINE_COLOR_EN
        CH_COLOR:   cmd[CMD_COLOR]   = 1'b1;
`endif
        default:    cmd = '0;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/text_line_manager.sv
// ============================================================================
// text_line_manager : turns a UART byte stream into committed text lines
// Build option      : TEXT_LINE_COLOR_EN adds per-line colour index
// Revision          : 1.0  initial release
// ============================================================================
`default_nettype none

module text_line_manager
  import text_line_pkg::*;
#(
  parameter  int NUM_LINES       = 4,
  parameter  int MAX_LINE_LENGTH = 10,
  parameter  int MAX_FONT_SIZE   = 3,
  parameter  int MIN_FONT_SIZE   = 0,
  localparam int LEN_W           = $clog2(MAX_LINE_LENGTH + 1),
  localparam int IDX_W           = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1,
  localparam int TB_W            = NUM_LINES * MAX_LINE_LENGTH * 8
)(
  input  logic                       system_clock,
  input  logic                       system_reset_n,
  input  logic [7:0]                 data_received,
  input  logic                       received_flag,
  output logic [TB_W-1:0]            text_buffer,
  output logic [NUM_LINES*LEN_W-1:0] line_length,
  output logic [NUM_LINES*2-1:0]     line_font,
  output logic [NUM_LINES*2-1:0]     line_color,
  output logic [IDX_W-1:0]           active_line,
  output logic                       line_ready,
  output logic                       overflow,
  output logic                       busy
);

  localparam int                  c_line_w    = MAX_LINE_LENGTH * 8;
  localparam logic [LEN_W-1:0]    c_max_len   = LEN_W'(MAX_LINE_LENGTH);
  localparam logic [IDX_W-1:0]    c_last_line = IDX_W'(NUM_LINES - 1);
  localparam attr_t               c_max_font  = attr_t'(MAX_FONT_SIZE);
  localparam attr_t               c_min_font  = attr_t'(MIN_FONT_SIZE);
  localparam logic [c_line_w-1:0] c_blank     = {MAX_LINE_LENGTH{CH_SPACE}};

  // Incoming byte is registered first, so its effect lands one edge later
  logic                       r_rx_flag;
  logic [7:0]                 r_rx_data;
  state_t                     r_state;
  logic                       r_busy;
  logic [IDX_W-1:0]           r_clr_idx;
  logic [IDX_W-1:0]           r_active;
  logic [TB_W-1:0]            r_text;
  logic [NUM_LINES*LEN_W-1:0] r_len;
  logic [NUM_LINES*2-1:0]     r_font;
  logic [c_line_w-1:0]        r_edit;
  logic [LEN_W-1:0]           r_edit_len;
  attr_t                      r_cur_font;
  logic                       r_line_ready;
  logic                       r_overflow;
  cmd_t                       w_cmd;

`ifdef TEXT_LINE_COLOR_EN
  logic [NUM_LINES*2-1:0]     r_color;
  attr_t                      r_cur_color;
`else
  logic                       w_unused_color;
  assign w_unused_color = w_cmd[CMD_COLOR];
`endif

  text_cmd_decoder u_decoder (
    .data (r_rx_data),
    .cmd  (w_cmd)
  );

  always_ff @(posedge system_clock) begin
    if (!system_reset_n) begin
      r_rx_flag    <= 1'b0;
      r_rx_data    <= 8'h00;
      r_state      <= IDLE;
      r_busy       <= 1'b0;
      r_clr_idx    <= '0;
      r_active     <= '0;
      r_text       <= {NUM_LINES{c_blank}};
      r_len        <= '0;
      r_font       <= {NUM_LINES{c_min_font}};
      r_edit       <= c_blank;
      r_edit_len   <= '0;
      r_cur_font   <= c_min_font;
      r_line_ready <= 1'b0;
      r_overflow   <= 1'b0;
`ifdef TEXT_LINE_COLOR_EN
      r_color      <= '0;
      r_cur_color  <= '0;
`endif
    end else begin
      r_rx_flag    <= received_flag;
      r_rx_data    <= data_received;
      r_line_ready <= 1'b0;
      r_overflow   <= 1'b0;

      case (r_state)
        IDLE: begin
          if (r_rx_flag) begin
            if (w_cmd[CMD_PRINT]) begin
              if (r_edit_len < c_max_len) begin
                for (int c = 0; c < MAX_LINE_LENGTH; c++) begin
                  if (r_edit_len == LEN_W'(c)) r_edit[c*8 +: 8] <= r_rx_data;
                end
                r_edit_len <= r_edit_len + 1'b1;
              end else begin
                r_overflow <= 1'b1;
              end
            end

            if (w_cmd[CMD_BS] && (r_edit_len != '0)) begin
              for (int c = 0; c < MAX_LINE_LENGTH; c++) begin
                if (r_edit_len == LEN_W'(c + 1)) r_edit[c*8 +: 8] <= CH_SPACE;
              end
              r_edit_len <= r_edit_len - 1'b1;
            end

            if (w_cmd[CMD_CR]) begin
              for (int l = 0; l < NUM_LINES; l++) begin
                if (r_active == IDX_W'(l)) begin
                  r_text[l*c_line_w +: c_line_w] <= r_edit;
                  r_len[l*LEN_W +: LEN_W]        <= r_edit_len;
                  r_font[l*2 +: 2]               <= r_cur_font;
`ifdef TEXT_LINE_COLOR_EN
                  r_color[l*2 +: 2]              <= r_cur_color;
`endif
                end
              end
              r_line_ready <= 1'b1;
              r_active     <= (r_active == c_last_line) ? '0 : r_active + 1'b1;
              r_edit       <= c_blank;
              r_edit_len   <= '0;
            end

            if (w_cmd[CMD_ESC]) begin
              r_edit     <= c_blank;
              r_edit_len <= '0;
            end

            if (w_cmd[CMD_FONT_UP] && (r_cur_font < c_max_font)) r_cur_font <= r_cur_font + 1'b1;
            if (w_cmd[CMD_FONT_DN] && (r_cur_font > c_min_font)) r_cur_font <= r_cur_font - 1'b1;

`ifdef TEXT_LINE_COLOR_EN
            if (w_cmd[CMD_COLOR]) r_cur_color <= r_cur_color + 1'b1;
`endif

            if (w_cmd[CMD_FF]) begin
              r_state   <= CLEAR;
              r_busy    <= 1'b1;
              r_clr_idx <= '0;
            end
          end
        end

        CLEAR: begin
          if (r_rx_flag) r_overflow <= 1'b1;
          for (int l = 0; l < NUM_LINES; l++) begin
            if (r_clr_idx == IDX_W'(l)) begin
              r_text[l*c_line_w +: c_line_w] <= c_blank;
              r_len[l*LEN_W +: LEN_W]        <= '0;
              r_font[l*2 +: 2]               <= c_min_font;
`ifdef TEXT_LINE_COLOR_EN
              r_color[l*2 +: 2]              <= '0;
`endif
            end
          end
          // Last line wiped: leave with a fresh edit buffer and line pointer
          if (r_clr_idx == c_last_line) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_clr_idx  <= '0;
            r_active   <= '0;
            r_edit     <= c_blank;
            r_edit_len <= '0;
          end else begin
            r_clr_idx <= r_clr_idx + 1'b1;
          end
        end

        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign text_buffer = r_text;
  assign line_length = r_len;
  assign line_font   = r_font;
  assign active_line = r_active;
  assign line_ready  = r_line_ready;
  assign overflow    = r_overflow;
  assign busy        = r_busy;

`ifdef TEXT_LINE_COLOR_EN
  assign line_color  = r_color;
`else
  assign line_color  = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_text_line_manager.sv
// ============================================================================
// tb_text_line_manager : scoreboard bench with a queue-based reference model
// Revision             : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_text_line_manager;
  import text_line_pkg::*;

  localparam int NUM_LINES = 4;
  localparam int MAXL      = 10;
  localparam int MAXF      = 3;
  localparam int MINF      = 0;
  localparam int LEN_W     = $clog2(MAXL + 1);
  localparam int IDX_W     = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
  localparam int TB_W      = NUM_LINES * MAXL * 8;

  logic                       system_clock = 1'b0;
  logic                       system_reset_n = 1'b0;
  logic [7:0]                 data_received = 8'h00;
  logic                       received_flag = 1'b0;
  logic [TB_W-1:0]            text_buffer;
  logic [NUM_LINES*LEN_W-1:0] line_length;
  logic [NUM_LINES*2-1:0]     line_font;
  logic [NUM_LINES*2-1:0]     line_color;
  logic [IDX_W-1:0]           active_line;
  logic                       line_ready;
  logic                       overflow;
  logic                       busy;

  text_line_manager #(
    .NUM_LINES       (NUM_LINES),
    .MAX_LINE_LENGTH (MAXL),
    .MAX_FONT_SIZE   (MAXF),
    .MIN_FONT_SIZE   (MINF)
  ) dut (
    .system_clock   (system_clock),
    .system_reset_n (system_reset_n),
    .data_received  (data_received),
    .received_flag  (received_flag),
    .text_buffer    (text_buffer),
    .line_length    (line_length),
    .line_font      (line_font),
    .line_color     (line_color),
    .active_line    (active_line),
    .line_ready     (line_ready),
    .overflow       (overflow),
    .busy           (busy)
  );

  always #5 system_clock = ~system_clock;

  int cyc = 0;
  always @(posedge system_clock) cyc <= cyc + 1;

  typedef struct {
    int                         cyc;
    logic [TB_W-1:0]            text;
    logic [NUM_LINES*LEN_W-1:0] len;
    logic [NUM_LINES*2-1:0]     font;
    logic [NUM_LINES*2-1:0]     color;
    logic [IDX_W-1:0]           active;
  } ev_t;

  ev_t ready_q[$];
  ev_t clear_q[$];
  int  ovf_q[$];

  int checks = 0;
  int errors = 0;

  // Reference model: committed lines as arrays, edit buffer as a byte queue
  byte unsigned m_text[NUM_LINES][MAXL];
  int           m_len[NUM_LINES];
  int           m_font[NUM_LINES];
  int           m_color[NUM_LINES];
  byte unsigned m_edit[$];
  int           m_active;
  int           m_cur_font;
  int           m_cur_color;
  int           m_ff_cyc;

  task automatic chk(input string name, input logic [TB_W-1:0] act, input logic [TB_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h required %0h", name, cyc, act, exp);
    end
  endtask

  function automatic ev_t snap(input int c);
    ev_t e;
    e.cyc = c;
    for (int l = 0; l < NUM_LINES; l++) begin
      for (int ch = 0; ch < MAXL; ch++) e.text[(l*MAXL + ch)*8 +: 8] = m_text[l][ch];
      e.len[l*LEN_W +: LEN_W] = LEN_W'(m_len[l]);
      e.font[l*2 +: 2]        = 2'(m_font[l]);
      e.color[l*2 +: 2]       = 2'(m_color[l]);
    end
    e.active = IDX_W'(m_active);
    return e;
  endfunction

  task automatic model_wipe_lines();
    for (int l = 0; l < NUM_LINES; l++) begin
      for (int ch = 0; ch < MAXL; ch++) m_text[l][ch] = 8'h20;
      m_len[l]   = 0;
      m_font[l]  = MINF;
      m_color[l] = 0;
    end
    m_active = 0;
    m_edit.delete();
  endtask

  task automatic model_reset();
    model_wipe_lines();
    m_cur_font  = MINF;
    m_cur_color = 0;
    m_ff_cyc    = -1000;
  endtask

  task automatic model_byte(input byte unsigned b, input int c);
    if ((c - m_ff_cyc >= 1) && (c - m_ff_cyc <= NUM_LINES)) begin
      ovf_q.push_back(c + 2);
    end else if (b >= 8'h20 && b <= 8'h7E) begin
      if (m_edit.size() < MAXL) m_edit.push_back(b);
      else ovf_q.push_back(c + 2);
    end else begin
      case (b)
        8'h08: if (m_edit.size() > 0) void'(m_edit.pop_back());
        8'h0D: begin
          for (int ch = 0; ch < MAXL; ch++)
            m_text[m_active][ch] = (ch < m_edit.size()) ? m_edit[ch] : 8'h20;
          m_len[m_active]   = m_edit.size();
          m_font[m_active]  = m_cur_font;
          m_color[m_active] = m_cur_color;
          m_active          = (m_active + 1) % NUM_LINES;
          m_edit.delete();
          ready_q.push_back(snap(c + 2));
        end
        8'h1B: m_edit.delete();
        8'h11: if (m_cur_font < MAXF) m_cur_font++;
        8'h12: if (m_cur_font > MINF) m_cur_font--;
        8'h0C: begin
          model_wipe_lines();
          m_ff_cyc = c;
          clear_q.push_back(snap(c + NUM_LINES + 2));
        end
`ifdef TEXT_LINE_COLOR_EN
        8'h13: m_cur_color = (m_cur_color + 1) % 4;
`endif
        default: ;
      endcase
    end
  endtask

  task automatic send(input byte unsigned b);
    @(negedge system_clock);
    data_received = b;
    received_flag = 1'b1;
    model_byte(b, cyc);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge system_clock);
      received_flag = 1'b0;
    end
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic check_reset_values();
    ev_t e;
    e = snap(0);
    chk("reset_text",   text_buffer,         e.text);
    chk("reset_len",    TB_W'(line_length),  TB_W'(e.len));
    chk("reset_font",   TB_W'(line_font),    TB_W'(e.font));
    chk("reset_color",  TB_W'(line_color),   TB_W'(e.color));
    chk("reset_active", TB_W'(active_line),  TB_W'(e.active));
    chk("reset_ready",  TB_W'(line_ready),   TB_W'(0));
    chk("reset_ovf",    TB_W'(overflow),     TB_W'(0));
    chk("reset_busy",   TB_W'(busy),         TB_W'(0));
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an event
  int busy_run = 0;
  initial begin
    ev_t e;
    forever begin
      @(negedge system_clock);
      if (!system_reset_n) begin
        busy_run = 0;
      end else begin
        if (line_ready) begin
          chk("ready_expected", TB_W'(ready_q.size() > 0), TB_W'(1));
          if (ready_q.size() > 0) begin
            e = ready_q.pop_front();
            chk("ready_cycle",  TB_W'(cyc),         TB_W'(e.cyc));
            chk("ready_text",   text_buffer,        e.text);
            chk("ready_len",    TB_W'(line_length), TB_W'(e.len));
            chk("ready_font",   TB_W'(line_font),   TB_W'(e.font));
            chk("ready_color",  TB_W'(line_color),  TB_W'(e.color));
            chk("ready_active", TB_W'(active_line), TB_W'(e.active));
          end
        end
        if (overflow) begin
          chk("ovf_expected", TB_W'(ovf_q.size() > 0), TB_W'(1));
          if (ovf_q.size() > 0) chk("ovf_cycle", TB_W'(cyc), TB_W'(ovf_q.pop_front()));
        end
        if (busy) begin
          busy_run++;
        end else if (busy_run > 0) begin
          chk("clear_expected", TB_W'(clear_q.size() > 0), TB_W'(1));
          if (clear_q.size() > 0) begin
            e = clear_q.pop_front();
            chk("busy_cycles",  TB_W'(busy_run),    TB_W'(NUM_LINES));
            chk("clear_cycle",  TB_W'(cyc),         TB_W'(e.cyc));
            chk("clear_text",   text_buffer,        e.text);
            chk("clear_len",    TB_W'(line_length), TB_W'(e.len));
            chk("clear_font",   TB_W'(line_font),   TB_W'(e.font));
            chk("clear_color",  TB_W'(line_color),  TB_W'(e.color));
            chk("clear_active", TB_W'(active_line), TB_W'(e.active));
          end
          busy_run = 0;
        end
      end
    end
  end

  initial begin
    int r;
    model_reset();
    repeat (3) @(negedge system_clock);
    check_reset_values();
    system_reset_n = 1'b1;
    idle(2);

    send_str("ABC"); send(8'h0D); idle(3);
    repeat (12) send("X");
    send(8'h0D); idle(3);
    send_str("AB"); send(8'h08); send(8'h08); send(8'h08);
    send("C"); send(8'h0D); idle(3);
    repeat (5) send(8'h11);
    send("Q"); send(8'h0D); idle(2);
    repeat (5) send(8'h12);
    send("R"); send(8'h0D); idle(3);
    send(8'h0D); idle(2);
    send(8'h0C); idle(1); send("K"); idle(NUM_LINES + 4);
    repeat (2) send(8'h13);
    send("Z"); send(8'h0D); idle(3);

    // Reset in the middle of an edit and a clear sweep
    send_str("HI"); idle(2);
    send(8'h0C); idle(2);
    @(negedge system_clock);
    system_reset_n = 1'b0;
    received_flag  = 1'b0;
    repeat (2) @(negedge system_clock);
    model_reset();
    clear_q.delete();
    check_reset_values();
    system_reset_n = 1'b1;
    idle(2);

    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      if      (r < 55) send(8'($urandom_range(32, 126)));
      else if (r < 63) send(8'h08);
      else if (r < 71) send(8'h0D);
      else if (r < 74) send(8'h1B);
      else if (r < 78) send(8'h11);
      else if (r < 82) send(8'h12);
      else if (r < 86) send(8'h13);
      else if (r < 88) send(8'h0C);
      else             send(8'($urandom_range(128, 255)));
      r = $urandom_range(0, 2);
      if (r > 0) idle(r);
    end
    idle(NUM_LINES + 6);

    chk("ready_q_drained", TB_W'(ready_q.size()), TB_W'(0));
    chk("ovf_q_drained",   TB_W'(ovf_q.size()),   TB_W'(0));
    chk("clear_q_drained", TB_W'(clear_q.size()), TB_W'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
